// File: rtl/fir_ctrl_pkg.sv
// Shared constants, reset-time coefficient set and controller state encoding
// for the symmetric FIR coefficient controller.
package fir_ctrl_pkg;

    localparam int WC_DEF = 18;
    localparam int N_DEF  = 24;
    localparam int NH_DEF = N_DEF / 2;

    localparam logic signed [WC_DEF-1:0] DEFAULT_COEF [NH_DEF] = '{
        18'sd454,    -18'sd342,  -18'sd1479,  -18'sd1138,
        18'sd2580,   18'sd6289,  18'sd2017,   -18'sd11143,
        -18'sd18470, -18'sd1403, 18'sd38404,  18'sd72928
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        SWAP,
        FLUSH
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks; shadow is written by the config port and
// committed to active on swap, or restored from active on abort.
// FIR_COEF_READBACK_EN adds a combinational shadow read port.
import fir_ctrl_pkg::*;

module fir_coef_bank #(
    parameter int WC = WC_DEF,
    parameter int NH = NH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [5:0]           wr_addr,
    input  logic signed [WC-1:0] wr_data,
    input  logic                 commit,
    input  logic                 restore,
`ifdef FIR_COEF_READBACK_EN
    input  logic [5:0]           rd_addr,
    output logic [WC-1:0]        rd_data,
`endif
    output logic [NH*WC-1:0]     active_flat
);

    logic [NH-1:0][WC-1:0] shadow_arr;
    logic [NH-1:0][WC-1:0] active_arr;

    for (genvar i = 0; i < NH; i++) begin : g_ent
        // Entries beyond the packaged default table reset to zero.
        localparam int DI = (i < NH_DEF) ? i : 0;
        localparam logic [WC-1:0] RST_V = (i < NH_DEF) ? WC'(DEFAULT_COEF[DI]) : '0;

        logic [WC-1:0] shadow_q;
        logic [WC-1:0] active_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_q <= RST_V;
                active_q <= RST_V;
            end else begin
                if (restore)
                    shadow_q <= active_q;
                else if (wr_en && wr_addr == 6'(i))
                    shadow_q <= wr_data;
                if (commit)
                    active_q <= shadow_q;
            end
        end

        assign shadow_arr[i] = shadow_q;
        assign active_arr[i] = active_q;
    end

    assign active_flat = active_arr;

`ifdef FIR_COEF_READBACK_EN
    localparam int AW = $clog2(NH);
    assign rd_data = (rd_addr < 6'(NH)) ? shadow_arr[rd_addr[AW-1:0]] : '0;
`endif

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient controller: loads a shadow set, swaps it in on a boundary
// strobe and mutes the filter while stale products flush. Option: FIR_COEF_READBACK_EN.
//   state | meaning
//   IDLE  | waiting for the first write of a set
//   LOAD  | partial set written, more writes expected
//   ARMED | set complete, waiting for swap_en
//   SWAP  | single cycle, shadow copied to active
//   FLUSH | pipeline draining under mute
import fir_ctrl_pkg::*;

module fir_coef_ctrl #(
    parameter int WC        = WC_DEF,
    parameter int N         = N_DEF,
    parameter int FLUSH_LEN = N + 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [5:0]             cfg_addr,
    input  logic signed [WC-1:0]   cfg_data,
    input  logic                   cfg_last,
    input  logic                   abort,
    input  logic                   swap_en,
    output logic [(N/2)*WC-1:0]    coef_bus,
    output logic                   flt_mute,
    output logic                   cfg_err,
    output logic                   swap_done,
    output logic                   busy
`ifdef FIR_COEF_READBACK_EN
    ,
    input  logic [5:0]             rb_addr,
    output logic [WC-1:0]          rb_data
`endif
);

    localparam int NH = N / 2;
    localparam int CW = $clog2(FLUSH_LEN + 1);

    state_t        state, state_nx;
    logic [CW-1:0] flush_cnt;
    logic          accept, pend_abort, wr_en, addr_oor;

    assign accept     = cfg_valid && cfg_ready;
    assign pend_abort = abort && (state == LOAD || state == ARMED);
    assign wr_en      = accept && !pend_abort;
    assign addr_oor   = cfg_addr >= 6'(NH);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = cfg_last ? ARMED : LOAD;
            LOAD: begin
                if (pend_abort)             state_nx = IDLE;
                else if (accept && cfg_last) state_nx = ARMED;
            end
            ARMED: begin
                if (pend_abort)   state_nx = IDLE;
                else if (swap_en) state_nx = SWAP;
            end
            SWAP:    state_nx = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef FIR_COEF_READBACK_EN
    logic [WC-1:0] bank_rd;
`endif

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            cfg_ready <= 1'b1;
            flt_mute  <= 1'b0;
            cfg_err   <= 1'b0;
            swap_done <= 1'b0;
            busy      <= 1'b0;
`ifdef FIR_COEF_READBACK_EN
            rb_data   <= '0;
`endif
        end else begin
            state     <= state_nx;
            cfg_ready <= (state_nx == IDLE) || (state_nx == LOAD);
            busy      <= (state_nx != IDLE);
            flt_mute  <= (state_nx == SWAP) || (state_nx == FLUSH);
            swap_done <= (state == FLUSH) && (state_nx == IDLE);
            if (state == SWAP)
                flush_cnt <= CW'(FLUSH_LEN - 1);
            else if (state == FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - CW'(1);
            if (state_nx == SWAP)
                cfg_err <= 1'b0;
            else if (wr_en && addr_oor)
                cfg_err <= 1'b1;
`ifdef FIR_COEF_READBACK_EN
            rb_data   <= bank_rd;
`endif
        end
    end

    fir_coef_bank #(
        .WC (WC),
        .NH (NH)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (cfg_addr),
        .wr_data     (cfg_data),
        .commit      (state == SWAP),
        .restore     (pend_abort),
`ifdef FIR_COEF_READBACK_EN
        .rd_addr     (rb_addr),
        .rd_data     (bank_rd),
`endif
        .active_flat (coef_bus)
    );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: directed scenarios plus randomized
// coefficient sets checked against a shadow/active array model.
module tb_fir_coef_ctrl;

    localparam int WC = 18;
    localparam int N  = 24;
    localparam int NH = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_last = 1'b0;
    logic              abort = 1'b0;
    logic              swap_en = 1'b0;
    logic [5:0]        cfg_addr = '0;
    logic signed [WC-1:0] cfg_data = '0;
    logic              cfg_ready, flt_mute, cfg_err, swap_done, busy;
    logic [NH*WC-1:0]  coef_bus;
`ifdef FIR_COEF_READBACK_EN
    logic [5:0]        rb_addr = '0;
    logic [WC-1:0]     rb_data;
`endif

    always #5 clk = ~clk;

    fir_coef_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .abort     (abort),
        .swap_en   (swap_en),
        .coef_bus  (coef_bus),
        .flt_mute  (flt_mute),
        .cfg_err   (cfg_err),
        .swap_done (swap_done),
        .busy      (busy)
`ifdef FIR_COEF_READBACK_EN
        ,
        .rb_addr   (rb_addr),
        .rb_data   (rb_data)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    int dflt [NH] = '{454, -342, -1479, -1138, 2580, 6289, 2017, -11143, -18470, -1403, 38404, 72928};
    int m_shadow [NH];
    int m_active [NH];
    bit m_err;

    function automatic void model_reset();
        for (int k = 0; k < NH; k++) begin
            m_shadow[k] = dflt[k];
            m_active[k] = dflt[k];
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_write(input int addr, input int data);
        if (addr < NH) m_shadow[addr] = data;
        else           m_err = 1'b1;
    endfunction

    function automatic void model_commit();
        for (int k = 0; k < NH; k++) m_active[k] = m_shadow[k];
        m_err = 1'b0;
    endfunction

    function automatic void model_restore();
        for (int k = 0; k < NH; k++) m_shadow[k] = m_active[k];
    endfunction

    function automatic logic [NH*WC-1:0] model_bus();
        logic [NH*WC-1:0] r;
        r = '0;
        for (int k = 0; k < NH; k++) r[k*WC +: WC] = WC'(m_active[k]);
        return r;
    endfunction

    function automatic int sl(input logic [NH*WC-1:0] b, input int idx);
        logic signed [WC-1:0] s;
        s = b[idx*WC +: WC];
        return int'(s);
    endfunction

    function automatic int rnd_coef();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_write(input int addr, input int data, input bit last, input bit ab);
        cfg_valid = 1'b1;
        cfg_addr  = 6'(addr);
        cfg_data  = WC'(data);
        cfg_last  = last;
        abort     = ab;
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        abort     = 1'b0;
    endtask

    // Pulses swap_en once and records the fixed-length window that follows.
    task automatic run_swap(output bit mute_e1, output bit err_e1,
                            output logic [NH*WC-1:0] bus_e1, output logic [NH*WC-1:0] bus_e2,
                            output int mute_len, output int done_cnt);
        swap_en = 1'b1;
        step();
        swap_en = 1'b0;
        mute_e1  = flt_mute;
        err_e1   = cfg_err;
        bus_e1   = coef_bus;
        bus_e2   = '0;
        mute_len = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 1) bus_e2 = coef_bus;
            if (flt_mute) mute_len++;
            if (swap_done) done_cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
        n_cmp++; if (sl(coef_bus, 0) !== 454) begin n_bad++; $display("FAIL reset_slice0: got %0d want 454", sl(coef_bus, 0)); end
        n_cmp++; if (sl(coef_bus, 11) !== 72928) begin n_bad++; $display("FAIL reset_slice11: got %0d want 72928", sl(coef_bus, 11)); end
        n_cmp++; if (coef_bus !== model_bus()) begin n_bad++; $display("FAIL reset_bus: got %h want %h", coef_bus, model_bus()); end
        n_cmp++; if ({cfg_ready, flt_mute, cfg_err, swap_done, busy} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_flags: got rdy/mute/err/done/busy=%b want 10000", {cfg_ready, flt_mute, cfg_err, swap_done, busy});
        end
    endtask

    task automatic test_full_set();
        bit mute_e1, err_e1;
        logic [NH*WC-1:0] bus_e1, bus_e2, old_bus;
        int mute_len, done_cnt;
        for (int i = 0; i < NH; i++) begin
            drive_write(i, 100 * i, i == NH - 1, 1'b0);
            model_write(i, 100 * i);
        end
        n_cmp++; if ({cfg_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL full_armed: got rdy/busy=%b want 01", {cfg_ready, busy}); end
        repeat (5) step();
        old_bus = model_bus();
        run_swap(mute_e1, err_e1, bus_e1, bus_e2, mute_len, done_cnt);
        model_commit();
        n_cmp++; if (mute_e1 !== 1'b1) begin n_bad++; $display("FAIL full_mute_rise: got %b want 1", mute_e1); end
        n_cmp++; if (bus_e1 !== old_bus) begin n_bad++; $display("FAIL full_bus_e1: got %h want %h", bus_e1, old_bus); end
        n_cmp++; if (sl(bus_e2, 11) !== 1100) begin n_bad++; $display("FAIL full_slice11: got %0d want 1100", sl(bus_e2, 11)); end
        n_cmp++; if (bus_e2 !== model_bus()) begin n_bad++; $display("FAIL full_bus_e2: got %h want %h", bus_e2, model_bus()); end
        n_cmp++; if (mute_len !== 28) begin n_bad++; $display("FAIL full_mute_len: got %0d want 28", mute_len); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if ({cfg_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL full_idle: got rdy/busy=%b want 10", {cfg_ready, busy}); end
    endtask

    task automatic test_abort();
        bit mute_e1, err_e1;
        logic [NH*WC-1:0] bus_e1, bus_e2;
        int mute_len, done_cnt;
        apply_reset();
        drive_write(3, -5, 1'b1, 1'b0);
        model_write(3, -5);
        swap_en = 1'b1;
        abort   = 1'b1;
        step();
        swap_en = 1'b0;
        abort   = 1'b0;
        model_restore();
        n_cmp++; if ({cfg_ready, busy, flt_mute} !== 3'b100) begin
            n_bad++; $display("FAIL abort_idle: got rdy/busy/mute=%b want 100", {cfg_ready, busy, flt_mute});
        end
        repeat (3) step();
        n_cmp++; if (flt_mute !== 1'b0) begin n_bad++; $display("FAIL abort_no_swap: got mute %b want 0", flt_mute); end
        n_cmp++; if (sl(coef_bus, 3) !== -1138) begin n_bad++; $display("FAIL abort_slice3: got %0d want -1138", sl(coef_bus, 3)); end
        drive_write(0, 77, 1'b1, 1'b0);
        model_write(0, 77);
        run_swap(mute_e1, err_e1, bus_e1, bus_e2, mute_len, done_cnt);
        model_commit();
        n_cmp++; if (bus_e2 !== model_bus()) begin n_bad++; $display("FAIL abort_later_bus: got %h want %h", bus_e2, model_bus()); end
        n_cmp++; if (sl(coef_bus, 3) !== -1138) begin n_bad++; $display("FAIL abort_later_slice3: got %0d want -1138", sl(coef_bus, 3)); end
        n_cmp++; if (sl(coef_bus, 0) !== 77) begin n_bad++; $display("FAIL abort_later_slice0: got %0d want 77", sl(coef_bus, 0)); end
    endtask

    task automatic test_out_of_range();
        bit mute_e1, err_e1;
        logic [NH*WC-1:0] bus_e1, bus_e2, old_bus;
        int mute_len, done_cnt;
        drive_write(40, 7, 1'b1, 1'b0);
        model_write(40, 7);
        n_cmp++; if ({cfg_err, cfg_ready} !== 2'b10) begin n_bad++; $display("FAIL oor_err_set: got err/rdy=%b want 10", {cfg_err, cfg_ready}); end
        old_bus = model_bus();
        run_swap(mute_e1, err_e1, bus_e1, bus_e2, mute_len, done_cnt);
        model_commit();
        n_cmp++; if (err_e1 !== 1'b0) begin n_bad++; $display("FAIL oor_err_clear: got %b want 0", err_e1); end
        n_cmp++; if (bus_e2 !== old_bus) begin n_bad++; $display("FAIL oor_bus: got %h want %h", bus_e2, old_bus); end
    endtask

    task automatic test_reset_mid_flush();
        drive_write(2, 1234, 1'b1, 1'b0);
        model_write(2, 1234);
        swap_en = 1'b1;
        step();
        swap_en = 1'b0;
        repeat (10) step();
        n_cmp++; if (flt_mute !== 1'b1) begin n_bad++; $display("FAIL flush_muted: got %b want 1", flt_mute); end
        reset = 1'b1;
        step();
        model_reset();
        n_cmp++; if (flt_mute !== 1'b0) begin n_bad++; $display("FAIL rst_flush_mute: got %b want 0", flt_mute); end
        n_cmp++; if (coef_bus !== model_bus()) begin n_bad++; $display("FAIL rst_flush_bus: got %h want %h", coef_bus, model_bus()); end
        n_cmp++; if ({cfg_ready, busy, swap_done, cfg_err} !== 4'b1000) begin
            n_bad++; $display("FAIL rst_flush_flags: got rdy/busy/done/err=%b want 1000", {cfg_ready, busy, swap_done, cfg_err});
        end
        reset = 1'b0;
        step();
        n_cmp++; if ({flt_mute, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_flush_after: got mute/busy=%b want 00", {flt_mute, busy}); end
    endtask

    task automatic test_random();
        bit mute_e1, err_e1, do_abort;
        logic [NH*WC-1:0] bus_e1, bus_e2;
        int mute_len, done_cnt, nw, addr, data;
        for (int it = 0; it < 10; it++) begin
            swap_en = 1'b1;
            step();
            swap_en = 1'b0;
            n_cmp++; if ({flt_mute, busy} !== 2'b00) begin n_bad++; $display("FAIL rnd_stray_swap it%0d: got mute/busy=%b want 00", it, {flt_mute, busy}); end
            nw = int'($urandom_range(1, 6));
            do_abort = ($urandom_range(0, 3) == 0);
            for (int w = 0; w < nw; w++) begin
                addr = int'($urandom_range(0, 15));
                data = rnd_coef();
                drive_write(addr, data, (w == nw - 1) && !do_abort, 1'b0);
                model_write(addr, data);
            end
            if (do_abort) begin
                drive_write(int'($urandom_range(0, NH - 1)), rnd_coef(), 1'b0, 1'b1);
                model_restore();
                n_cmp++; if ({busy, cfg_err} !== {1'b0, m_err}) begin
                    n_bad++; $display("FAIL rnd_abort it%0d: got busy/err=%b want 0%b", it, {busy, cfg_err}, m_err);
                end
                n_cmp++; if (coef_bus !== model_bus()) begin n_bad++; $display("FAIL rnd_abort_bus it%0d: got %h want %h", it, coef_bus, model_bus()); end
            end else begin
                n_cmp++; if ({cfg_err, cfg_ready} !== {m_err, 1'b0}) begin
                    n_bad++; $display("FAIL rnd_armed it%0d: got err/rdy=%b want %b0", it, {cfg_err, cfg_ready}, m_err);
                end
                repeat ($urandom_range(0, 4)) step();
                run_swap(mute_e1, err_e1, bus_e1, bus_e2, mute_len, done_cnt);
                model_commit();
                n_cmp++; if (bus_e2 !== model_bus()) begin n_bad++; $display("FAIL rnd_bus it%0d: got %h want %h", it, bus_e2, model_bus()); end
                n_cmp++; if ({err_e1, mute_e1} !== 2'b01) begin n_bad++; $display("FAIL rnd_swap_entry it%0d: got err/mute=%b want 01", it, {err_e1, mute_e1}); end
                n_cmp++; if (mute_len !== 28 || done_cnt !== 1) begin
                    n_bad++; $display("FAIL rnd_flush it%0d: got mute_len %0d done %0d want 28 1", it, mute_len, done_cnt);
                end
            end
        end
    endtask

`ifdef FIR_COEF_READBACK_EN
    task automatic test_readback();
        int got;
        apply_reset();
        n_cmp++; if (rb_data !== '0) begin n_bad++; $display("FAIL rb_reset: got %0d want 0", rb_data); end
        drive_write(5, 321, 1'b0, 1'b0);
        model_write(5, 321);
        rb_addr = 6'd5;
        step();
        got = int'(signed'(rb_data));
        n_cmp++; if (got !== m_shadow[5]) begin n_bad++; $display("FAIL rb_addr5: got %0d want %0d", got, m_shadow[5]); end
        rb_addr = 6'd40;
        step();
        n_cmp++; if (rb_data !== '0) begin n_bad++; $display("FAIL rb_oor: got %0d want 0", rb_data); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        model_restore();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_set();
        test_abort();
        test_out_of_range();
        test_reset_mid_flush();
        test_random();
`ifdef FIR_COEF_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Run-time coefficient configuration controller for the symmetric FIR filter (W=20 data, WC=18 coefficients, N taps, N/2 unique coefficients).
- Accepts coefficient writes into a shadow bank over a valid/ready interface, then swaps shadow to active on a system-supplied boundary strobe.
- Asserts a mute window while the filter pipeline flushes stale products.
- Sits between the register/config bus and the filter's parallel coefficient inputs.

Parameters:
- WC, 18, coefficient width (signed).
- N, 24, filter taps; multiple of 4, N<=64; NH=N/2 coefficients are stored.
- FLUSH_LEN, 27, mute cycles after swap (N+3 = filter pipeline depth).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  write request.
- cfg_ready  out  1  controller can accept a write.
- cfg_addr  in  6  coefficient index.
- cfg_data  in  WC  signed coefficient.
- cfg_last  in  1  final write of the set; arms the swap.
- abort  in  1  discard the pending set.
- swap_en  in  1  sample/frame boundary strobe.
- coef_bus  out  NH*WC  active coefficients; index i at bits [i*WC +: WC].
- flt_mute  out  1  downstream must zero the filter output.
- cfg_err  out  1  sticky out-of-range address flag.
- swap_done  out  1  one-cycle pulse at end of flush.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs registered. Reset values:
  - coef_bus = DEFAULT_COEF from the package; shadow bank = DEFAULT_COEF.
  - cfg_ready=1, flt_mute=0, cfg_err=0, swap_done=0, busy=0.
  - State = IDLE.
- A write is accepted when cfg_valid & cfg_ready. Shadow[cfg_addr] updates on the next edge.
- States:
  - IDLE: cfg_ready=1. Accepted write without last -> LOAD. Accepted write with last -> ARMED.
  - LOAD: cfg_ready=1. Accepted write with last -> ARMED.
  - ARMED: cfg_ready=0. swap_en -> SWAP.
  - SWAP: one cycle; active <= shadow; counter <= FLUSH_LEN-1; flt_mute<=1; -> FLUSH.
  - FLUSH: counter decrements each cycle. At counter==0: -> IDLE, flt_mute<=0, swap_done pulses for 1 cycle. flt_mute is high for exactly FLUSH_LEN+1 cycles, counting from the SWAP edge.
- Latency: coef_bus changes 2 edges after the swap_en sample in ARMED.
- Out-of-range write (cfg_addr>=NH): still accepted (handshake completes, cfg_last still honoured); data dropped; cfg_err<=1.
- cfg_err clears on reset or on SWAP entry.
- Partial sets are legal; unwritten shadow entries keep their prior values.
- abort in LOAD or ARMED: -> IDLE next edge; shadow <= active (pending writes discarded); a same-cycle write is discarded.
- abort in IDLE, SWAP or FLUSH: ignored.
- abort & swap_en together in ARMED: abort wins.
- swap_en outside ARMED: ignored.
- Repeated writes to the same address: last one wins.
- reset mid-LOAD or mid-FLUSH: everything returns to reset values in 1 cycle; active reverts to DEFAULT_COEF; flt_mute drops immediately.
- Coefficient data is passed through unmodified; no arithmetic or saturation.

Optional Feature:
- Macro FIR_COEF_READBACK_EN.
- Defined: adds ports rb_addr (in, 6) and rb_data (out, WC).
  - rb_data is registered and equals shadow[rb_addr] 1 cycle later.
  - Out-of-range rb_addr returns 0.
  - rb_data resets to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package fir_ctrl_pkg:
  - WC_DEF, N_DEF, NH_DEF constants.
  - DEFAULT_COEF array holding the 12 default values: 454, -342, -1479, -1138, 2580, 6289, 2017, -11143, -18470, -1403, 38404, 72928.
  - State enum: IDLE, LOAD, ARMED, SWAP, FLUSH.
- Sub-module fir_coef_bank: shadow and active register banks with write port, copy-to-active, copy-to-shadow (abort) and flat active output.
- The FSM and flush counter stay in fir_coef_ctrl.

Test Plan:
- Reset release -> coef_bus slice 0 = 454, slice 11 = 72928; cfg_ready=1; flt_mute=0.
- Write addr 0..11 with value 100*i, last on addr 11, then swap_en 5 cycles later:
  - coef_bus slice 11 = 1100 two edges after swap_en.
  - flt_mute high for 28 cycles.
  - swap_done pulses once.
- Write addr 3 = -5 with last, then abort together with swap_en:
  - No swap occurs; slice 3 stays -1138.
  - A later set and swap with no write to addr 3 keeps -1138.
- Write addr 40 = 7 with last, then swap:
  - cfg_err=1 before the swap and 0 after SWAP entry.
  - No slice changes.
- Assert reset at flush cycle 10 -> flt_mute=0 and coef_bus = defaults on the next cycle; state IDLE.
- With FIR_COEF_READBACK_EN: write addr 5 = 321, then rb_addr=5 -> rb_data=321 one cycle later, before any swap.
